ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits between the ID/EX register and mem_stage.
- Performs ALU operations, operand/destination selection, and iterative MULT/MULTU/DIV/DIVU into HI/LO.
- Owns the EX/MEM pipeline register, so its outputs drive mem_stage inputs directly.
- Raises a stall interlock when an instruction needs HI/LO or the mult/div unit while that unit is busy.

Parameters:
- WIDTH, 32: datapath width.
- MD_CYCLES, 32: iterations per multiply/divide; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  ID/EX holds a valid instruction
- flush  in  1  force a bubble into EX/MEM this cycle
- ReadData1  in  32  rs operand
- ReadData2  in  32  rt operand
- SignImm  in  32  sign-extended immediate
- ALUSrc  in  1  1 = SignImm is operand B
- ALUOp  in  2  00 add, 01 sub, 10 R-type (use Funct), 11 reserved (treated as add)
- Funct  in  6  R-type function field
- RegDst  in  1  1 = Rd, 0 = Rt
- Rt  in  5  rt field
- Rd  in  5  rd field
- WBControl_in  in  2  passed through
- MemWrite_in, MemRead_in, Branch_in  in  1 each  passed through
- ALUResult  out  32  registered result
- WriteData  out  32  registered ReadData2
- WriteReg  out  5  registered destination register
- WBControl  out  2  registered
- MemWrite, MemRead, Branch  out  1 each  registered
- Zero  out  1  registered (ALU result == 0)
- stall  out  1  combinational; upstream holds ID/EX and PC while high
- md_busy  out  1  multiply/divide unit iterating

Behaviour:
- Reset: all registered outputs are 0; HI and LO are 0; the FSM is IDLE; md_busy is 0.
- Operand B is SignImm when ALUSrc=1, otherwise ReadData2.
- ALU is combinational. EX/MEM outputs update on the next rising edge (latency 1).
- R-type Funct decode:
  - 0x20/0x21 add, wrapping, no trap.
  - 0x22/0x23 subtract, wrapping.
  - 0x24 and; 0x25 or; 0x26 xor; 0x27 nor.
  - 0x2A slt (signed); 0x2B sltu.
  - 0x00 sll, 0x02 srl, 0x03 sra: shift amount is SignImm[10:6], applied to ReadData2.
  - 0x10 mfhi, 0x12 mflo: result is HI or LO.
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu: ALU result is 0 and the WBControl output is forced to 00.
  - Any other Funct: result 0.
- Bubble: when any of stall, flush or !in_valid is true, the next edge loads WBControl, MemWrite, MemRead, Branch = 0. Data fields are don't-care but are loaded with 0.
- Mult/div FSM states: IDLE, MUL, DIV.
  - Accept: in IDLE with in_valid=1, flush=0 and a mult/div Funct, latch magnitudes and signedness. Then move to MUL or DIV with count=0 and md_busy=1.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring, one quotient bit per cycle.
  - On the edge where count==MD_CYCLES-1, write HI/LO and return to IDLE.
  - md_busy is therefore high for exactly 32 cycles after the accept edge.
- Result placement:
  - mult: {HI,LO} = 64-bit product; signed variants negate when the operand signs differ.
  - div: LO = quotient, HI = remainder. The quotient is negated when signs differ; the remainder takes the dividend's sign.
- Divide by zero: LO=0xFFFFFFFF and HI=dividend for unsigned; for signed, the same values with the sign fix-up applied.
- 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- Stall condition: md_busy AND in_valid AND Funct ∈ {mfhi, mflo, mult, multu, div, divu} AND ALUOp=10.
  - Stall deasserts in the cycle after the final edge, so a held MFHI then reads the new HI.
- flush does not cancel an already-accepted mult/div.
- Asserting rst mid-operation aborts the iteration immediately and clears HI/LO.

Optional Feature:
- FAST_MULT_EN defined: MULT/MULTU complete in a single cycle using a combinational 64-bit multiply. HI/LO are written on the accept edge and md_busy never asserts for multiplies. DIV is unchanged.
- FAST_MULT_EN undefined: 32-cycle iterative multiply as described above.

Decomposition:
- Package ex_pkg holds:
  - ALUOp encodings and Funct localparams (F_ADD, F_SLT, F_MULT, F_MFHI, …);
  - the FSM state enum;
  - the 64-bit product type.
- Sub-module muldiv_unit owns the FSM, HI/LO, the iteration datapath and the FAST_MULT_EN path. It exposes start, op, a, b, busy, hi and lo.

Test Plan:
- Reset: with the EX/MEM outputs and HI/LO carrying nonzero values, asserting rst clears ALUResult, WBControl and HI/LO to 0 at once, without waiting for clk.
- Add-immediate: ReadData1=0x10, SignImm=0x4, ALUSrc=1, ALUOp=00, RegDst=0, Rt=2 → next edge ALUResult=0x14, WriteReg=2, Zero=0.
- Branch compare: ReadData1=ReadData2=0x55, ALUOp=01, Branch_in=1 → Zero=1, Branch=1 after one edge.
- Signed multiply: MULT of 0xFFFFFFFE (-2) and 3; MFHI issued the next cycle. Expect stall high for 31 cycles, then MFHI yields HI=0xFFFFFFFF and MFLO yields 0xFFFFFFFA. No MemWrite/WBControl bubble leakage while stalled.
- Divide boundaries: DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- Flush/reset mid-op: flush during DIV leaves md_busy high and the result still written. rst asserted at count=10 → md_busy=0 and HI=LO=0 immediately.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings and types for the MIPS execute stage and its multiply/divide unit.
package ex_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_RSVD  = 2'b11;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_state_t;

  typedef logic [63:0] prod_t;

  // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B: Funct[1] selects divide, Funct[0] unsigned.
  function automatic logic is_md_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and restoring divide into HI/LO.
// FAST_MULT_EN: multiplies complete on the accept edge with a combinational product.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MD_CYCLES);

  md_state_t        state, state_nxt;
  logic [CW-1:0]    count;
  logic             neg_q, neg_r;
  prod_t            acc, mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem, quo, dvsr;

  logic             a_neg, b_neg, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  prod_t            acc_step, prod_fin;
  logic [WIDTH:0]   rem_sh;
  logic             qbit;
  logic [WIDTH-1:0] rem_step, quo_step, q_fin, r_fin;
`ifdef FAST_MULT_EN
  prod_t            fast_prod, fast_fin;
`endif

  always_comb begin
    a_neg = !op[0] && a[WIDTH-1];
    b_neg = !op[0] && b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    last  = (count == CW'(MD_CYCLES - 1));

    acc_step = mplier[0] ? acc + mcand : acc;
    prod_fin = neg_q ? -acc_step : acc_step;

    // Restoring step: the divisor is always below 2^WIDTH, so a remainder that
    // fails the compare still fits back into WIDTH bits.
    rem_sh   = {rem, quo[WIDTH-1]};
    qbit     = (rem_sh >= {1'b0, dvsr});
    rem_step = qbit ? rem_sh[WIDTH-1:0] - dvsr : rem_sh[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], qbit};
    q_fin    = neg_q ? -quo_step : quo_step;
    r_fin    = neg_r ? -rem_step : rem_step;
`ifdef FAST_MULT_EN
    fast_prod = prod_t'(a_mag) * prod_t'(b_mag);
    fast_fin  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: begin
        if (start) begin
`ifdef FAST_MULT_EN
          state_nxt = op[1] ? MD_DIV : MD_IDLE;
`else
          state_nxt = op[1] ? MD_DIV : MD_MUL;
`endif
        end
      end
      MD_MUL, MD_DIV: if (last) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MD_IDLE;
      count  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        MD_IDLE: begin
          if (start) begin
            count  <= '0;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            acc    <= '0;
            mcand  <= prod_t'(a_mag);
            mplier <= b_mag;
            rem    <= '0;
            quo    <= a_mag;
            dvsr   <= b_mag;
`ifdef FAST_MULT_EN
            if (!op[1]) {hi, lo} <= fast_fin;
`endif
          end
        end
        MD_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last) {hi, lo} <= prod_fin;
        end
        MD_DIV: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count + CW'(1);
          if (last) begin
            lo <= q_fin;
            hi <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != MD_IDLE);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, operand/destination select, EX/MEM register and HI/LO interlock.
// FAST_MULT_EN (see muldiv_unit) makes MULT/MULTU single-cycle.
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] SignImm,
  input  logic             ALUSrc,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic             RegDst,
  input  logic [4:0]       Rt,
  input  logic [4:0]       Rd,
  input  logic [1:0]       WBControl_in,
  input  logic             MemWrite_in,
  input  logic             MemRead_in,
  input  logic             Branch_in,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] WriteData,
  output logic [4:0]       WriteReg,
  output logic [1:0]       WBControl,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             Branch,
  output logic             Zero,
  output logic             stall,
  output logic             md_busy
);

  logic [WIDTH-1:0] src_b, alu_res, hi, lo;
  logic [4:0]       shamt;
  logic             rtype, is_md, bubble, md_start;

  assign src_b    = ALUSrc ? SignImm : ReadData2;
  assign shamt    = SignImm[10:6];
  assign rtype    = (ALUOp == ALU_RTYPE);
  assign is_md    = rtype && is_md_funct(Funct);
  assign stall    = md_busy && in_valid && rtype &&
                    (is_md_funct(Funct) || Funct == F_MFHI || Funct == F_MFLO);
  assign bubble   = stall || flush || !in_valid;
  assign md_start = in_valid && !flush && is_md && !md_busy;

  muldiv_unit #(
    .WIDTH     (WIDTH),
    .MD_CYCLES (MD_CYCLES)
  ) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (Funct[1:0]),
    .a     (ReadData1),
    .b     (ReadData2),
    .busy  (md_busy),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      ALU_SUB: alu_res = ReadData1 - src_b;
      ALU_RTYPE: begin
        case (Funct)
          F_ADD, F_ADDU: alu_res = ReadData1 + src_b;
          F_SUB, F_SUBU: alu_res = ReadData1 - src_b;
          F_AND:  alu_res = ReadData1 & src_b;
          F_OR:   alu_res = ReadData1 | src_b;
          F_XOR:  alu_res = ReadData1 ^ src_b;
          F_NOR:  alu_res = ~(ReadData1 | src_b);
          F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(ReadData1) < $signed(src_b))};
          F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (ReadData1 < src_b)};
          F_SLL:  alu_res = ReadData2 << shamt;
          F_SRL:  alu_res = ReadData2 >> shamt;
          F_SRA:  alu_res = $signed(ReadData2) >>> shamt;
          F_MFHI: alu_res = hi;
          F_MFLO: alu_res = lo;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = ReadData1 + src_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      ALUResult <= '0;
      WriteData <= '0;
      WriteReg  <= '0;
      WBControl <= '0;
      MemWrite  <= 1'b0;
      MemRead   <= 1'b0;
      Branch    <= 1'b0;
      Zero      <= 1'b0;
    end else begin
      ALUResult <= alu_res;
      WriteData <= ReadData2;
      WriteReg  <= RegDst ? Rd : Rt;
      WBControl <= is_md ? 2'b00 : WBControl_in;
      MemWrite  <= MemWrite_in;
      MemRead   <= MemRead_in;
      Branch    <= Branch_in;
      Zero      <= (alu_res == '0);
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage (default build, iterative multiply).
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, flush, ALUSrc, RegDst;
  logic [31:0] ReadData1, ReadData2, SignImm;
  logic [1:0]  ALUOp, WBControl_in;
  logic [5:0]  Funct;
  logic [4:0]  Rt, Rd;
  logic        MemWrite_in, MemRead_in, Branch_in;
  logic [31:0] ALUResult, WriteData;
  logic [4:0]  WriteReg;
  logic [1:0]  WBControl;
  logic        MemWrite, MemRead, Branch, Zero, stall, md_busy;

  int tests = 0;
  int fails = 0;

  ex_stage #(.WIDTH(32), .MD_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .SignImm(SignImm),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Funct(Funct), .RegDst(RegDst),
    .Rt(Rt), .Rd(Rd), .WBControl_in(WBControl_in), .MemWrite_in(MemWrite_in),
    .MemRead_in(MemRead_in), .Branch_in(Branch_in), .ALUResult(ALUResult),
    .WriteData(WriteData), .WriteReg(WriteReg), .WBControl(WBControl),
    .MemWrite(MemWrite), .MemRead(MemRead), .Branch(Branch), .Zero(Zero),
    .stall(stall), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic src);
    in_valid = 1'b1; flush = 1'b0; ALUOp = op; Funct = f;
    ReadData1 = a; ReadData2 = b; SignImm = imm; ALUSrc = src;
    RegDst = 1'b1; Rt = 5'd2; Rd = 5'd9; WBControl_in = 2'b10;
    MemWrite_in = 1'b0; MemRead_in = 1'b0; Branch_in = 1'b0;
  endtask

  task automatic nop();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic read_hl(input logic [5:0] f, output logic [31:0] v);
    issue(2'b10, f, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    v = ALUResult;
    nop();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (md_busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    issue(2'b00, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    nop();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ALUResult, WriteData, WriteReg, WBControl, MemWrite, MemRead, Branch, Zero} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got res=%h wd=%h wr=%0d wb=%b mw=%b mr=%b br=%b z=%b expected all 0",
               ALUResult, WriteData, WriteReg, WBControl, MemWrite, MemRead, Branch, Zero);
    end
    tests++;
    if ({md_busy, stall} !== 2'b00) begin
      fails++;
      $display("FAIL reset_busy: got busy=%b stall=%b expected 0 0", md_busy, stall);
    end
    rst = 1'b0;
    read_hl(6'h10, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL reset_hi: got %h expected 00000000", v);
    end
  endtask

  task automatic test_addi();
    issue(2'b00, 6'h0, 32'h10, 32'h99, 32'h4, 1'b1);
    RegDst = 1'b0;
    tick();
    tests++;
    if ({ALUResult, WriteReg, Zero, WBControl} !== {32'h14, 5'd2, 1'b0, 2'b10}) begin
      fails++;
      $display("FAIL addi: got res=%h wr=%0d z=%b wb=%b expected res=00000014 wr=2 z=0 wb=10",
               ALUResult, WriteReg, Zero, WBControl);
    end
    nop();
  endtask

  task automatic test_branch();
    issue(2'b01, 6'h0, 32'h55, 32'h55, 32'h0, 1'b0);
    Branch_in = 1'b1;
    tick();
    tests++;
    if ({Zero, Branch, ALUResult, WriteData} !== {1'b1, 1'b1, 32'h0, 32'h55}) begin
      fails++;
      $display("FAIL branch_cmp: got z=%b br=%b res=%h wd=%h expected z=1 br=1 res=0 wd=55",
               Zero, Branch, ALUResult, WriteData);
    end
    nop();
  endtask

  task automatic test_rtype();
    logic [1:0]  vop [13] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [5:0]  vf  [13] = '{6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                              6'h00, 6'h02, 6'h03, 6'h21, 6'h3F, 6'h00};
    logic [31:0] va  [13] = '{32'h5, 32'hF0F0, 32'h0F, 32'hFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h7, 32'h7, 32'h7, 32'hFFFFFFFF, 32'h12, 32'h3};
    logic [31:0] vb  [13] = '{32'h7, 32'hFF00, 32'hF0, 32'h0F, 32'h0, 32'h1, 32'h1,
                              32'h1, 32'h80000000, 32'h80000000, 32'h2, 32'h34, 32'h4};
    logic [31:0] vi  [13] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                              32'h100, 32'h100, 32'h100, 32'h0, 32'h0, 32'h0};
    logic [31:0] ve  [13] = '{32'hFFFFFFFE, 32'hF000, 32'hFF, 32'hF0, 32'hFFFFFFFF, 32'h1, 32'h0,
                              32'h10, 32'h08000000, 32'hF8000000, 32'h1, 32'h0, 32'h7};
    for (int i = 0; i < 13; i++) begin
      issue(vop[i], vf[i], va[i], vb[i], vi[i], 1'b0);
      tick();
      tests++;
      if ({Zero, ALUResult, WriteReg} !== {(ve[i] == 32'h0), ve[i], 5'd9}) begin
        fails++;
        $display("FAIL rtype_%0d (op=%b f=%h): got z=%b res=%h wr=%0d expected z=%b res=%h wr=9",
                 i, vop[i], vf[i], Zero, ALUResult, WriteReg, (ve[i] == 32'h0), ve[i]);
      end
    end
    nop();
  endtask

  task automatic test_bubble();
    issue(2'b00, 6'h0, 32'h1, 32'h2, 32'h0, 1'b0);
    WBControl_in = 2'b11; MemWrite_in = 1'b1; MemRead_in = 1'b1; Branch_in = 1'b1;
    in_valid = 1'b0;
    tick();
    tests++;
    if ({ALUResult, WBControl, MemWrite, MemRead, Branch} !== '0) begin
      fails++;
      $display("FAIL bubble_invalid: got res=%h wb=%b mw=%b mr=%b br=%b expected all 0",
               ALUResult, WBControl, MemWrite, MemRead, Branch);
    end
    in_valid = 1'b1; flush = 1'b1;
    tick();
    tests++;
    if ({ALUResult, WBControl, MemWrite, MemRead, Branch} !== '0) begin
      fails++;
      $display("FAIL bubble_flush: got res=%h wb=%b mw=%b mr=%b br=%b expected all 0",
               ALUResult, WBControl, MemWrite, MemRead, Branch);
    end
    nop();
  endtask

  task automatic test_mult();
    int cnt, leak;
    logic [31:0] v;
    issue(2'b10, 6'h18, 32'hFFFFFFFE, 32'h3, 32'h0, 1'b0);
    tick();
    tests++;
    if ({md_busy, WBControl, ALUResult} !== {1'b1, 2'b00, 32'h0}) begin
      fails++;
      $display("FAIL mult_accept: got busy=%b wb=%b res=%h expected busy=1 wb=00 res=0",
               md_busy, WBControl, ALUResult);
    end
    nop();
    tick();
    issue(2'b10, 6'h10, 32'h0, 32'h0, 32'h0, 1'b0);
    MemWrite_in = 1'b1;
    #1;
    cnt = 0; leak = 0;
    while (stall === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
      if (WBControl !== 2'b00 || MemWrite !== 1'b0) leak++;
    end
    tests++;
    if (cnt != 31) begin
      fails++;
      $display("FAIL mult_stall_len: got %0d cycles expected 31", cnt);
    end
    tests++;
    if (leak != 0) begin
      fails++;
      $display("FAIL mult_stall_leak: got %0d leaking cycles expected 0", leak);
    end
    tick();
    tests++;
    if ({ALUResult, WBControl, MemWrite} !== {32'hFFFFFFFF, 2'b10, 1'b1}) begin
      fails++;
      $display("FAIL mult_mfhi: got res=%h wb=%b mw=%b expected res=ffffffff wb=10 mw=1",
               ALUResult, WBControl, MemWrite);
    end
    nop();
    read_hl(6'h12, v);
    tests++;
    if (v !== 32'hFFFFFFFA) begin
      fails++;
      $display("FAIL mult_mflo: got %h expected fffffffa", v);
    end
  endtask

  task automatic test_div();
    logic [5:0]  df [3] = '{6'h1B, 6'h1A, 6'h1A};
    logic [31:0] da [3] = '{32'h7, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] db [3] = '{32'h0, 32'h2, 32'hFFFFFFFF};
    logic [31:0] dl [3] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
    logic [31:0] dh [3] = '{32'h7, 32'hFFFFFFFF, 32'h0};
    logic [31:0] lo_v, hi_v;
    int n;
    for (int i = 0; i < 3; i++) begin
      issue(2'b10, df[i], da[i], db[i], 32'h0, 1'b0);
      tick();
      nop();
      wait_idle(n);
      tests++;
      if (n != 32) begin
        fails++;
        $display("FAIL div_%0d_busy_len: got %0d cycles expected 32", i, n);
      end
      read_hl(6'h12, lo_v);
      read_hl(6'h10, hi_v);
      tests++;
      if ({lo_v, hi_v} !== {dl[i], dh[i]}) begin
        fails++;
        $display("FAIL div_%0d (%h / %h): got lo=%h hi=%h expected lo=%h hi=%h",
                 i, da[i], db[i], lo_v, hi_v, dl[i], dh[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    read_hl(6'h12, v);
    tests++;
    if ({ALUResult, WBControl} !== {32'h80000000, 2'b10}) begin
      fails++;
      $display("FAIL areset_pre: got res=%h wb=%b expected res=80000000 wb=10", ALUResult, WBControl);
    end
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({ALUResult, WBControl, dut.u_md.hi, dut.u_md.lo} !== '0) begin
      fails++;
      $display("FAIL areset_now: got res=%h wb=%b hi=%h lo=%h expected all 0",
               ALUResult, WBControl, dut.u_md.hi, dut.u_md.lo);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_flush_mid();
    logic [31:0] lo_v, hi_v;
    int n;
    issue(2'b10, 6'h1B, 32'd100, 32'd7, 32'h0, 1'b0);
    tick();
    nop();
    repeat (3) tick();
    issue(2'b00, 6'h0, 32'h1, 32'h1, 32'h0, 1'b0);
    flush = 1'b1;
    repeat (3) tick();
    tests++;
    if ({md_busy, WBControl} !== {1'b1, 2'b00}) begin
      fails++;
      $display("FAIL flush_mid_busy: got busy=%b wb=%b expected busy=1 wb=00", md_busy, WBControl);
    end
    nop();
    wait_idle(n);
    read_hl(6'h12, lo_v);
    read_hl(6'h10, hi_v);
    tests++;
    if ({lo_v, hi_v} !== {32'd14, 32'd2}) begin
      fails++;
      $display("FAIL flush_mid_result: got lo=%h hi=%h expected lo=0000000e hi=00000002 (wait %0d)",
               lo_v, hi_v, n);
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] v;
    issue(2'b10, 6'h1A, 32'd50, 32'd3, 32'h0, 1'b0);
    tick();
    nop();
    repeat (10) tick();
    tests++;
    if ({md_busy, dut.u_md.count} !== {1'b1, 5'd10}) begin
      fails++;
      $display("FAIL rst_mid_pre: got busy=%b count=%0d expected busy=1 count=10",
               md_busy, dut.u_md.count);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({md_busy, dut.u_md.hi, dut.u_md.lo} !== '0) begin
      fails++;
      $display("FAIL rst_mid_now: got busy=%b hi=%h lo=%h expected all 0",
               md_busy, dut.u_md.hi, dut.u_md.lo);
    end
    rst = 1'b0;
    tick();
    read_hl(6'h12, v);
    tests++;
    if ({v, md_busy} !== {32'h0, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid_lo: got lo=%h busy=%b expected lo=0 busy=0", v, md_busy);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_rtype();
    test_bubble();
    test_mult();
    test_div();
    test_async_reset();
    test_flush_mid();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
